// File: rtl/vector_range_pkg.sv
// Shared constants and types for the range-check consumer stage.
package vector_range_pkg;

  localparam int unsigned LANES = 12;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 4;

  typedef logic [WIDTH-1:0] sample_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set mask bit, plus a flag when exactly one bit is set.
module lowest_set_index #(
  parameter int unsigned LANES = 12,
  parameter int unsigned IDX_W = 4
) (
  input  logic [LANES-1:0] mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic             single_o
);

  logic [LANES-1:0] mask_minus_one;

  always_comb begin
    index_o = '0;
    // Walk downwards so the lowest set bit wins.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

  assign mask_minus_one = mask_i - LANES'(1);
  assign single_o       = (mask_i != '0) && ((mask_i & mask_minus_one) == '0);

endmodule

// File: rtl/vector_error_reporter.sv
// Captures one lane vector plus its error mask and serialises each flagged lane as an
// (index, value) record on a valid/ready stream, lowest lane first.
module vector_error_reporter #(
  parameter int unsigned LANES = vector_range_pkg::LANES,
  parameter int unsigned WIDTH = vector_range_pkg::WIDTH,
  parameter int unsigned IDX_W = vector_range_pkg::IDX_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [LANES*WIDTH-1:0] vectorIn,
  input  logic [LANES-1:0]       errorPos,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [IDX_W-1:0]       outIndex,
  output logic [WIDTH-1:0]       outValue,
  output logic                   outLast,
  output logic [CNT_W-1:0]       errorTotal,
  output logic [CNT_W-1:0]       cleanFrames
);

  import vector_range_pkg::*;

  state_e                 state_q, state_d;
  logic [LANES*WIDTH-1:0] vec_q, vec_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [CNT_W-1:0]       err_q, err_d;
  logic [CNT_W-1:0]       clean_q, clean_d;

  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_single;
  logic [WIDTH-1:0] sel_value;
  logic             scan;

  lowest_set_index #(
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_lowest_set_index (
    .mask_i  (mask_q),
    .index_o (lsb_idx),
    .single_o(lsb_single)
  );

  assign scan = (state_q == SCAN);

  // Lane mux driven purely from registered state.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lsb_idx == IDX_W'(i)) begin
        sel_value = vec_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign inReady     = !scan;
  assign outValid    = scan;
  assign outIndex    = scan ? lsb_idx : '0;
  assign outValue    = scan ? sel_value : '0;
  assign outLast     = scan && lsb_single;
  assign errorTotal  = err_q;
  assign cleanFrames = clean_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    err_d   = err_q;
    clean_d = clean_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          vec_d  = vectorIn;
          mask_d = errorPos;
          if (errorPos == '0) begin
            if (clean_q != '1) begin
              clean_d = clean_q + CNT_W'(1);
            end
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (outReady) begin
          for (int i = 0; i < LANES; i++) begin
            if (lsb_idx == IDX_W'(i)) begin
              mask_d[i] = 1'b0;
            end
          end
          if (err_q != '1) begin
            err_d = err_q + CNT_W'(1);
          end
          if (lsb_single) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      clean_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      clean_q <= clean_d;
    end
  end

endmodule

// File: tb/tb_vector_error_reporter.sv
// Directed bench for vector_error_reporter; a second instance with 2-bit counters checks saturation.
module tb_vector_error_reporter;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [95:0] vectorIn;
  logic [11:0] errorPos;
  logic        outValid;
  logic        outReady;
  logic [3:0]  outIndex;
  logic [7:0]  outValue;
  logic        outLast;
  logic [15:0] errorTotal;
  logic [15:0] cleanFrames;

  logic        s_inReady;
  logic        s_outValid;
  logic [3:0]  s_outIndex;
  logic [7:0]  s_outValue;
  logic        s_outLast;
  logic [1:0]  s_errorTotal;
  logic [1:0]  s_cleanFrames;

  int compared;
  int mismatched;

  vector_error_reporter dut (
    .clock      (clock),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .vectorIn   (vectorIn),
    .errorPos   (errorPos),
    .outValid   (outValid),
    .outReady   (outReady),
    .outIndex   (outIndex),
    .outValue   (outValue),
    .outLast    (outLast),
    .errorTotal (errorTotal),
    .cleanFrames(cleanFrames)
  );

  vector_error_reporter #(
    .CNT_W(2)
  ) dut_sat (
    .clock      (clock),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (s_inReady),
    .vectorIn   (vectorIn),
    .errorPos   (errorPos),
    .outValid   (s_outValid),
    .outReady   (outReady),
    .outIndex   (s_outIndex),
    .outValue   (s_outValue),
    .outLast    (s_outLast),
    .errorTotal (s_errorTotal),
    .cleanFrames(s_cleanFrames)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [3:0] idx, input logic [7:0] val,
                         input logic last);
    chk({tag, ".valid"}, {31'd0, outValid}, 32'd1);
    chk({tag, ".index"}, {28'd0, outIndex}, {28'd0, idx});
    chk({tag, ".value"}, {24'd0, outValue}, {24'd0, val});
    chk({tag, ".last"}, {31'd0, outLast}, {31'd0, last});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    inValid    = 1'b0;
    outReady   = 1'b1;
    vectorIn   = '0;
    errorPos   = '0;
    tick();
    tick();

    // Reset state
    chk("rst.inReady", {31'd0, inReady}, 32'd1);
    chk("rst.outValid", {31'd0, outValid}, 32'd0);
    chk("rst.outLast", {31'd0, outLast}, 32'd0);
    chk("rst.outIndex", {28'd0, outIndex}, 32'd0);
    chk("rst.outValue", {24'd0, outValue}, 32'd0);
    chk("rst.errorTotal", {16'd0, errorTotal}, 32'd0);
    chk("rst.cleanFrames", {16'd0, cleanFrames}, 32'd0);
    reset = 1'b0;
    tick();

    // Clean frames, back-to-back
    vectorIn = {12{8'h5A}};
    errorPos = 12'h000;
    inValid  = 1'b1;
    tick();
    chk("clean1.outValid", {31'd0, outValid}, 32'd0);
    chk("clean1.count", {16'd0, cleanFrames}, 32'd1);
    chk("clean1.inReady", {31'd0, inReady}, 32'd1);
    chk("clean1.outValue", {24'd0, outValue}, 32'd0);
    tick();
    chk("clean2.count", {16'd0, cleanFrames}, 32'd2);
    chk("clean2.outValid", {31'd0, outValid}, 32'd0);
    inValid = 1'b0;
    tick();
    chk("clean2.hold", {16'd0, cleanFrames}, 32'd2);

    // Two errors, outReady=1
    vectorIn          = {12{8'h33}};
    vectorIn[7:0]     = 8'h05;
    vectorIn[47:40]   = 8'hFA;
    errorPos          = 12'h021;
    inValid           = 1'b1;
    tick();
    inValid = 1'b0;
    chk_rec("two.r0", 4'd0, 8'h05, 1'b0);
    chk("two.inReady0", {31'd0, inReady}, 32'd0);
    tick();
    chk_rec("two.r1", 4'd5, 8'hFA, 1'b1);
    tick();
    chk("two.inReady", {31'd0, inReady}, 32'd1);
    chk("two.outValid", {31'd0, outValid}, 32'd0);
    chk("two.errorTotal", {16'd0, errorTotal}, 32'd2);

    // Backpressure; inValid with a different frame must be ignored while scanning
    outReady = 1'b0;
    inValid  = 1'b1;
    tick();
    vectorIn = {12{8'hC3}};
    errorPos = 12'h000;
    for (int k = 0; k < 5; k++) begin
      chk_rec("bp.hold", 4'd0, 8'h05, 1'b0);
      chk("bp.inReady", {31'd0, inReady}, 32'd0);
      tick();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    chk_rec("bp.r0", 4'd0, 8'h05, 1'b0);
    tick();
    chk_rec("bp.r1", 4'd5, 8'hFA, 1'b1);
    tick();
    chk("bp.outValid", {31'd0, outValid}, 32'd0);
    chk("bp.errorTotal", {16'd0, errorTotal}, 32'd4);
    chk("bp.cleanFrames", {16'd0, cleanFrames}, 32'd2);

    // All lanes flagged, lane i = i
    for (int i = 0; i < 12; i++) vectorIn[i*8 +: 8] = 8'(i);
    errorPos = 12'hFFF;
    inValid  = 1'b1;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk_rec("all.rec", 4'(i), 8'(i), (i == 11));
      tick();
    end
    chk("all.outValid", {31'd0, outValid}, 32'd0);
    chk("all.errorTotal", {16'd0, errorTotal}, 32'd16);

    // Reset after the first record of a two-record frame
    vectorIn         = '0;
    vectorIn[7:0]    = 8'hAA;
    vectorIn[95:88]  = 8'hBB;
    errorPos         = 12'h801;
    inValid          = 1'b1;
    tick();
    inValid = 1'b0;
    chk_rec("mid.r0", 4'd0, 8'hAA, 1'b0);
    tick();
    chk_rec("mid.r1", 4'd11, 8'hBB, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid.outValid", {31'd0, outValid}, 32'd0);
    chk("mid.errorTotal", {16'd0, errorTotal}, 32'd0);
    chk("mid.cleanFrames", {16'd0, cleanFrames}, 32'd0);
    chk("mid.inReady", {31'd0, inReady}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    vectorIn         = '0;
    vectorIn[23:16]  = 8'h44;
    errorPos         = 12'h004;
    inValid          = 1'b1;
    tick();
    inValid = 1'b0;
    chk_rec("post.r0", 4'd2, 8'h44, 1'b1);
    tick();
    chk("post.errorTotal", {16'd0, errorTotal}, 32'd1);
    chk("post.outValid", {31'd0, outValid}, 32'd0);

    // Saturation on the 2-bit counter instance
    errorPos = 12'h000;
    inValid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("sat.clean", {30'd0, s_cleanFrames}, (k > 3) ? 32'd3 : 32'(k));
    end
    inValid = 1'b0;
    tick();
    chk("sat.hold", {30'd0, s_cleanFrames}, 32'd3);
    chk("sat.wide", {16'd0, cleanFrames}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
